// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter for syn_fifo: round-robin with burst lock of up to BURST_LEN words.
// Optional per-source transfer counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int BCNT_W    = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              src0_req,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ack,
  input  logic              src1_req,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ack,
  input  logic              fifo_full,
  output logic              fifo_wr_req,
  output logic [DATA_W-1:0] fifo_data_in,
`ifdef FIFO_ARB_STATS_EN
  output logic [1:0]        gnt,
  output logic [31:0]       src0_words,
  output logic [31:0]       src1_words
`else
  output logic [1:0]        gnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              last_q, last_d;

  logic own_req;
  logic xfer;

  // A word moves only while the owner requests and the FIFO has room.
  assign own_req = ((state_q == OWN0) && src0_req) || ((state_q == OWN1) && src1_req);
  assign xfer    = own_req && !fifo_full;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // last_q==1 means src1 was served last, so src0 wins a tie.
        if (src0_req && (!src1_req || last_q)) state_d = OWN0;
        else if (src1_req)                     state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req || (xfer && (bcnt_q == BURST_LAST))) begin
          state_d = IDLE;
          bcnt_d  = '0;
          last_d  = (state_q == OWN1);
        end else if (xfer) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt          = 2'b00;
    src0_ack     = 1'b0;
    src1_ack     = 1'b0;
    fifo_wr_req  = 1'b0;
    fifo_data_in = '0;
    case (state_q)
      OWN0: begin
        gnt         = 2'b01;
        src0_ack    = xfer;
        fifo_wr_req = xfer;
        if (xfer) fifo_data_in = src0_data;
      end
      OWN1: begin
        gnt         = 2'b10;
        src1_ack    = xfer;
        fifo_wr_req = xfer;
        if (xfer) fifo_data_in = src1_data;
      end
      default: ;
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] src0_words_q, src0_words_d;
  logic [31:0] src1_words_q, src1_words_d;

  always_comb begin
    src0_words_d = src0_words_q;
    src1_words_d = src1_words_q;
    if (xfer && (state_q == OWN0)) src0_words_d = src0_words_q + 32'd1;
    if (xfer && (state_q == OWN1)) src1_words_d = src1_words_q + 32'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      src0_words_q <= '0;
      src1_words_q <= '0;
    end else begin
      src0_words_q <= src0_words_d;
      src1_words_q <= src1_words_d;
    end
  end

  assign src0_words = src0_words_q;
  assign src1_words = src1_words_q;
`endif

endmodule
